// File: rtl/uart_rx_buffered_if.sv
// Peripheral bus port of the buffered UART receiver: one-cycle request, one-cycle acknowledge.
interface uart_rx_buffered_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid, mem_addr, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with a small byte FIFO, popped one byte per bus read.
// Optional even-parity frame support is enabled by defining UART_RX_PARITY_EN.
module uart_rx_buffered #(
    parameter int unsigned clk_divider_bit = 217,
    parameter int unsigned buffer_depth    = 4,
    parameter logic [31:0] base_addr       = 32'h0100_0004
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               uart_rx,
    uart_rx_buffered_if.slave  bus
);

    localparam int unsigned CNT_W  = (clk_divider_bit > 2) ? $clog2(clk_divider_bit) : 1;
    localparam int unsigned PTR_W  = $clog2(buffer_depth);
    localparam int unsigned FCNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(clk_divider_bit / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(clk_divider_bit - 1);
    localparam logic [FCNT_W-1:0] DEPTH     = FCNT_W'(buffer_depth);
    localparam logic [31:0]       ADDR_MASK = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [7:0]          fifo_q [buffer_depth];
    logic [7:0]          fifo_d [buffer_depth];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                frame_err_q, frame_err_d;
    logic                parity_err_q, parity_err_d;
    logic                parity_bad_q, parity_bad_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                rx_s_c;
    logic                push_c;
    logic                frame_bad_c;
    logic                parity_hit_c;
    logic                sel_c;
    logic                rd_c;
    logic                not_empty_c;
    logic                pop_c;
    logic                push_ok_c;
    logic [7:0]          head_c;

    assign rx_s_c = sync2_q;

    // Receive FSM: synchroniser, bit timing and byte assembly
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shift_d      = shift_q;
        sync1_d      = uart_rx;
        sync2_d      = sync1_q;
        parity_bad_d = parity_bad_q;
        push_c       = 1'b0;
        frame_bad_c  = 1'b0;
        parity_hit_c = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_c) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s_c) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_c;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d        = '0;
                    parity_bad_d = ^{shift_q, rx_s_c};
                    parity_hit_c = ^{shift_q, rx_s_c};
                    state_d      = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!rx_s_c) begin
                        frame_bad_c = 1'b1;
                    end else if (!parity_bad_q) begin
                        push_c = 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // FIFO, sticky flags and the registered bus response
    always_comb begin
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;

        sel_c       = bus.mem_valid && ((bus.mem_addr & ADDR_MASK) == (base_addr & ADDR_MASK));
        rd_c        = sel_c && (bus.mem_wstrb == 4'h0);
        not_empty_c = (count_q != '0);
        pop_c       = rd_c && not_empty_c;
        push_ok_c   = push_c && ((count_q != DEPTH) || pop_c);
        head_c      = not_empty_c ? fifo_q[rd_ptr_q] : 8'h00;

        ready_d = sel_c;
        rdata_d = '0;
        if (rd_c) begin
            rdata_d = {20'h0_0000, parity_err_q, frame_err_q, ovf_q, not_empty_c, head_c};
            ovf_d        = 1'b0;
            frame_err_d  = 1'b0;
            parity_err_d = 1'b0;
        end

        // Events in the same cycle as a clearing read win
        if (push_c && !push_ok_c) ovf_d        = 1'b1;
        if (frame_bad_c)          frame_err_d  = 1'b1;
        if (parity_hit_c)         parity_err_d = 1'b1;

        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok_c) begin
            fifo_d[wr_ptr_q] = shift_q;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        case ({push_ok_c, pop_c})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            for (int i = 0; i < int'(buffer_depth); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            parity_bad_q <= 1'b0;
            ready_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            parity_bad_q <= parity_bad_d;
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;

endmodule
